fetch_prefetch_queue: RTL

Parametrised instruction fetch front-end that replaces the single-instruction fetch stage. It streams sequential requests to instruction memory over a valid/ready request channel and buffers in-order responses in a DEPTH-entry queue tagged with their PC. Decode consumes entries over a valid/ready handshake. A redirect from exec (branch or jump) flushes the queue and squashes responses still in flight.

---
 rtl/fetch_prefetch_queue.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front-end with a prefetch queue.
// Sequential requests stream to instruction memory under a credit limit. In-order
// responses land in a DEPTH-entry queue tagged with their PC, and decode drains the
// head over a valid/ready handshake. A redirect flushes the queue, restarts fetch at
// the new PC and arranges for responses still in flight to be discarded on arrival.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst_data,
    output logic [XLEN-1:0]            inst_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    // Counter width, pointer width, and a wider width for summing counters
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + 2;

    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [SW-1:0]   DEPTH_S    = SW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_reg,    fetch_pc_next;
    logic [XLEN-1:0] rsp_pc_reg,      rsp_pc_next;
    logic [CW-1:0]   count_reg,       count_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_cnt_reg,    drop_cnt_next;
    logic [PW-1:0]   wr_ptr_reg,      wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg,      rd_ptr_next;

    // Queue storage; contents need no reset because count gates visibility
    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    // Handshake and bookkeeping terms
    logic [SW-1:0]   credit_used;
    logic [SW-1:0]   drop_sum;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic            req_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;

    // Credit check and handshake decode; responses during a redirect or drop window are discarded
    always_comb begin
        credit_used         = SW'(count_reg) + SW'(outstanding_reg) + SW'(drop_cnt_reg);
        redirect_pc_aligned = redirect_pc & ALIGN_MASK;

        imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_S);
        imem_req_addr  = fetch_pc_reg;
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_drop = imem_rsp_valid && (drop_cnt_reg != '0);
        push     = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;

        inst_valid = (count_reg != '0);
        pop        = inst_valid && inst_ready && !redirect_valid;

        inst_data = data_mem[rd_ptr_reg];
        inst_pc   = pc_mem[rd_ptr_reg];
        occupancy = count_reg;
    end

    // Next-state computation; a redirect overrides every other update
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        count_next       = count_reg;
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        drop_sum         = SW'(drop_cnt_reg) + SW'(outstanding_reg);

        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving now consumes one of them
            if (imem_rsp_valid && (drop_sum != '0)) begin
                drop_sum = drop_sum - SW'(1);
            end
            fetch_pc_next    = redirect_pc_aligned;
            rsp_pc_next      = redirect_pc_aligned;
            count_next       = '0;
            outstanding_next = '0;
            drop_cnt_next    = CW'(drop_sum);
            wr_ptr_next      = '0;
            rd_ptr_next      = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
            if (push) begin
                rsp_pc_next = rsp_pc_reg + PC_STEP;
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            outstanding_next = outstanding_reg + CW'(req_fire) - CW'(push);
            count_next       = count_reg + CW'(push) - CW'(pop);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

    // Queue write port: response word and its PC tag go in at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rsp_data;
            pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
        end
    end

    // Occupancy never exceeds the queue size
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_reg <= DEPTH_C);

    // Buffered plus in-flight plus to-be-dropped never exceeds the credit pool
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credit_used <= DEPTH_S);

    // A push into a full queue would mean the credit scheme was violated
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_reg == DEPTH_C)));

endmodule
